audio_in_monitor: RTL and testbench



---
 rtl/audio_in_pkg.sv | 29 ++
 rtl/sample_magnitude.sv | 22 ++
 rtl/audio_in_monitor.sv | 136 +++++++++++++
 tb/tb_audio_in_monitor.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_in_pkg.sv
// Shared types, widths and the saturating absolute-value helper for the
// audio input monitor.
package audio_in_pkg;

  localparam int MAG_W     = 8;
  localparam int SAMPLE_W  = 32;
  localparam int HOLDOFF_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_MAG  = 2'd2,
    S_DET  = 2'd3
  } state_e;

  function automatic logic [SAMPLE_W-2:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] neg;
    neg = '0 - x;
    if (!x[SAMPLE_W-1]) begin
      return x[SAMPLE_W-2:0];
    end else if (neg[SAMPLE_W-1]) begin
      // only the most negative value stays negative after negation
      return '1;
    end else begin
      return neg[SAMPLE_W-2:0];
    end
  endfunction

endpackage

// File: rtl/sample_magnitude.sv
// Combinational stereo magnitude: saturating |L|, |R|, take the larger and
// keep its top MAG_W bits (truncated).
module sample_magnitude
  import audio_in_pkg::*;
(
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic [MAG_W-1:0]    mag8
);

  logic [SAMPLE_W-2:0] abs_l;
  logic [SAMPLE_W-2:0] abs_r;
  logic [SAMPLE_W-2:0] mag31;

  always_comb begin
    abs_l = sat_abs(left);
    abs_r = sat_abs(right);
    mag31 = (abs_l > abs_r) ? abs_l : abs_r;
    mag8  = MAG_W'(mag31 >> (SAMPLE_W - 1 - MAG_W));
  end

endmodule

// File: rtl/audio_in_monitor.sv
// Drains the codec input FIFO, tracks a decaying peak level and fires a
// one-cycle trigger on loud sounds with holdoff and hysteresis re-arm.
//
// state  | meaning
// S_IDLE | wait for a sample pair; capture both channels when available
// S_POP  | read_audio_in high, pops the pair just captured
// S_MAG  | register the 8-bit magnitude of the captured pair
// S_DET  | update level, holdoff, armed flag and trigger
module audio_in_monitor
  import audio_in_pkg::*;
#(
  parameter logic [MAG_W-1:0]     THRESH_HI       = 8'd96,
  parameter logic [MAG_W-1:0]     THRESH_LO       = 8'd32,
  parameter logic [HOLDOFF_W-1:0] HOLDOFF_SAMPLES = 16'd12000,
  parameter logic [7:0]           DECAY_SAMPLES   = 8'd64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  output logic                read_audio_in,
  output logic [MAG_W-1:0]    level,
  output logic                trigger,
  output logic [7:0]          trig_count,
  output logic                armed
);

  state_e                state_q, state_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic [MAG_W-1:0]      mag_q, mag_d;
  logic [MAG_W-1:0]      level_q, level_d;
  logic [7:0]            decay_q, decay_d;
  logic [HOLDOFF_W-1:0]  holdoff_q, holdoff_d;
  logic [7:0]            trig_count_q, trig_count_d;
  logic                  armed_q, armed_d;
  logic                  trigger_q, trigger_d;
  logic [MAG_W-1:0]      mag_comb;
  logic                  fire;

  sample_magnitude u_mag (
    .left  (left_q),
    .right (right_q),
    .mag8  (mag_comb)
  );

  always_comb begin
    state_d      = state_q;
    left_d       = left_q;
    right_d      = right_q;
    mag_d        = mag_q;
    level_d      = level_q;
    decay_d      = decay_q;
    holdoff_d    = holdoff_q;
    trig_count_d = trig_count_q;
    armed_d      = armed_q;
    trigger_d    = 1'b0;
    fire         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (audio_in_available) begin
          left_d  = left_channel_audio_in;
          right_d = right_channel_audio_in;
          state_d = S_POP;
        end
      end
      S_POP: state_d = S_MAG;
      S_MAG: begin
        mag_d   = mag_comb;
        state_d = S_DET;
      end
      S_DET: begin
        state_d = S_IDLE;

        if (mag_q > level_q) begin
          level_d = mag_q;
          decay_d = '0;
        end else if (decay_q == DECAY_SAMPLES - 8'd1) begin
          decay_d = '0;
          if (level_q != '0) level_d = level_q - MAG_W'(1);
        end else begin
          decay_d = decay_q + 8'd1;
        end

        // detector decisions all use the values held before this sample
        fire = enable && armed_q && (holdoff_q == '0) && (mag_q >= THRESH_HI);
        if (fire) begin
          trigger_d    = 1'b1;
          armed_d      = 1'b0;
          holdoff_d    = HOLDOFF_SAMPLES;
          trig_count_d = trig_count_q + 8'd1;
        end else begin
          if (holdoff_q != '0) holdoff_d = holdoff_q - HOLDOFF_W'(1);
          if (!armed_q && (holdoff_q == '0) && (mag_q < THRESH_LO)) armed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      left_q       <= '0;
      right_q      <= '0;
      mag_q        <= '0;
      level_q      <= '0;
      decay_q      <= '0;
      holdoff_q    <= '0;
      trig_count_q <= '0;
      armed_q      <= 1'b1;
      trigger_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      right_q      <= right_d;
      mag_q        <= mag_d;
      level_q      <= level_d;
      decay_q      <= decay_d;
      holdoff_q    <= holdoff_d;
      trig_count_q <= trig_count_d;
      armed_q      <= armed_d;
      trigger_q    <= trigger_d;
    end
  end

  assign read_audio_in = (state_q == S_POP);
  assign level         = level_q;
  assign trigger       = trigger_q;
  assign trig_count    = trig_count_q;
  assign armed         = armed_q;

endmodule

// File: tb/tb_audio_in_monitor.sv
// Scoreboard bench for audio_in_monitor: a FIFO model feeds samples, a
// reference model queues expected results, a monitor compares at N+4.
module tb_audio_in_monitor;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic [7:0]  level;
  logic        trigger;
  logic [7:0]  trig_count;
  logic        armed;

  audio_in_monitor #(
    .THRESH_HI       (8'd96),
    .THRESH_LO       (8'd32),
    .HOLDOFF_SAMPLES (16'd4),
    .DECAY_SAMPLES   (8'd64)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .level                  (level),
    .trigger                (trigger),
    .trig_count             (trig_count),
    .armed                  (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       trig;
    logic [7:0] level;
    logic [7:0] cnt;
    logic       armed;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_l[$];
  logic [31:0] fifo_r[$];
  int          hs_cycles[$];
  int          checks = 0;
  int          errors = 0;
  int          outstanding = 0;
  int          cyc = 0;
  logic        mon_en = 1'b1;
  logic        hs_rec = 1'b0;

  logic [7:0]  m_level, m_decay, m_cnt;
  logic [15:0] m_hold;
  logic        m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] ref_mag(input logic [31:0] l, input logic [31:0] r);
    longint al, ar, m;
    al = longint'($signed(l));
    ar = longint'($signed(r));
    if (al < 0) al = -al;
    if (ar < 0) ar = -ar;
    if (al > 64'sd2147483647) al = 64'sd2147483647;
    if (ar > 64'sd2147483647) ar = 64'sd2147483647;
    m = (al > ar) ? al : ar;
    return 8'(m / 64'sd8388608);
  endfunction

  task automatic model_reset();
    m_level = 8'd0;
    m_decay = 8'd0;
    m_cnt   = 8'd0;
    m_hold  = 16'd0;
    m_armed = 1'b1;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    logic [7:0]  mag;
    logic [15:0] old_hold;
    logic        fire;
    exp_t        e;
    mag      = ref_mag(l, r);
    old_hold = m_hold;
    fire     = enable && m_armed && (old_hold == 16'd0) && (mag >= 8'd96);
    if (mag > m_level) begin
      m_level = mag;
      m_decay = 8'd0;
    end else if (m_decay == 8'd63) begin
      m_decay = 8'd0;
      if (m_level != 8'd0) m_level = m_level - 8'd1;
    end else begin
      m_decay = m_decay + 8'd1;
    end
    if (fire) begin
      m_armed = 1'b0;
      m_hold  = 16'd4;
      m_cnt   = m_cnt + 8'd1;
    end else begin
      if (old_hold != 16'd0) m_hold = old_hold - 16'd1;
      if (!m_armed && old_hold == 16'd0 && mag < 8'd32) m_armed = 1'b1;
    end
    e.trig  = fire;
    e.level = m_level;
    e.cnt   = m_cnt;
    e.armed = m_armed;
    exp_q.push_back(e);
    fifo_l.push_back(l);
    fifo_r.push_back(r);
    outstanding++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (outstanding != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(outstanding == 0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // FIFO model: pops on read_audio_in, presents the head pair mid-cycle
  initial begin
    audio_in_available     = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (read_audio_in) begin
        check("read_while_avail", 32'(audio_in_available), 32'd1);
        if (hs_rec) hs_cycles.push_back(cyc);
        if (fifo_l.size() > 0) begin
          void'(fifo_l.pop_front());
          void'(fifo_r.pop_front());
        end
      end
      audio_in_available = (fifo_l.size() > 0);
      if (fifo_l.size() > 0) begin
        left_channel_audio_in  = fifo_l[0];
        right_channel_audio_in = fifo_r[0];
      end
    end
  end

  initial begin
    logic prev_read, prev_trig;
    prev_read = 1'b0;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (read_audio_in) check("read_one_cycle", 32'(prev_read), 32'd0);
      if (trigger) check("trigger_one_cycle", 32'(prev_trig), 32'd0);
      prev_read = read_audio_in;
      prev_trig = trigger;
    end
  end

  // results of a pop become visible three cycles after the pop cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (read_audio_in && mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: pop with no queued expectation (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          repeat (3) @(negedge clk);
          check("sb_trigger", 32'(trigger), 32'(e.trig));
          check("sb_level", 32'(level), 32'(e.level));
          check("sb_trig_count", 32'(trig_count), 32'(e.cnt));
          check("sb_armed", 32'(armed), 32'(e.armed));
          outstanding--;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_trig_count", 32'(trig_count), 32'd0);
    check("rst_armed", 32'(armed), 32'd1);
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_read", 32'(read_audio_in), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // handshake: three queued quiet pairs
    hs_rec = 1'b1;
    send(32'h0100_0000, 32'h0000_0000);
    send(32'h0000_0000, 32'hFF00_0000);
    send(32'h0080_0000, 32'h0000_0000);
    drain();
    hs_rec = 1'b0;
    check("hs_pop_count", 32'(hs_cycles.size()), 32'd3);
    if (hs_cycles.size() == 3) begin
      check("hs_gap1", 32'(hs_cycles[1] - hs_cycles[0]), 32'd4);
      check("hs_gap2", 32'(hs_cycles[2] - hs_cycles[1]), 32'd4);
    end

    // fire then disarm
    send(32'h3000_0000, 32'h0000_0000);
    drain();
    check("fire_count", 32'(trig_count), 32'd1);
    check("fire_armed", 32'(armed), 32'd0);
    check("fire_level", 32'(level), 32'd96);
    send(32'h3000_0000, 32'h0000_0000);

    // holdoff: four loud samples in total, then a quiet one re-arms
    send(32'h0000_0000, 32'hD000_0000);
    send(32'h2000_0000, 32'h3000_0000);
    send(32'h3000_0000, 32'h3000_0000);
    drain();
    check("holdoff_count", 32'(trig_count), 32'd1);
    check("holdoff_armed", 32'(armed), 32'd0);
    send(32'h0800_0000, 32'h0000_0000);
    drain();
    check("rearm_armed", 32'(armed), 32'd1);
    send(32'hD000_0000, 32'h0000_0000);
    drain();
    check("refire_count", 32'(trig_count), 32'd2);

    // saturation and decay
    send(32'h8000_0000, 32'h0000_0000);
    drain();
    check("sat_level", 32'(level), 32'd255);
    for (int i = 0; i < 128; i++) send(32'h0, 32'h0);
    drain();
    check("decay_level", 32'(level), 32'd253);

    // enable low: level follows, no trigger
    enable = 1'b0;
    send(32'h7FFF_FFFF, 32'h0000_0000);
    drain();
    check("dis_level", 32'(level), 32'd255);
    check("dis_count", 32'(trig_count), 32'd2);
    check("dis_armed", 32'(armed), 32'd1);
    enable = 1'b1;

    // count up to 255, then wrap
    for (int i = 0; i < 253; i++) begin
      send(32'h3000_0000, 32'h0);
      for (int j = 0; j < 5; j++) send(32'h0, 32'h0);
    end
    drain();
    check("count_255", 32'(trig_count), 32'd255);
    send(32'h3000_0000, 32'h0);
    drain();
    check("count_wrap", 32'(trig_count), 32'd0);

    // reset while the sample sits in S_MAG
    mon_en = 1'b0;
    fifo_l.push_back(32'h3000_0000);
    fifo_r.push_back(32'h0);
    n = 0;
    while (!read_audio_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_pop", 32'(read_audio_in), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_read", 32'(read_audio_in), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_count", 32'(trig_count), 32'd0);
    check("mid_rst_armed", 32'(armed), 32'd1);
    check("mid_rst_trigger", 32'(trigger), 32'd0);
    @(negedge clk);
    check("mid_rst_idle_read", 32'(read_audio_in), 32'd0);
    model_reset();
    mon_en = 1'b1;
    reset  = 1'b0;
    send(32'h3000_0000, 32'h0);
    drain();
    check("mid_replay_count", 32'(trig_count), 32'd1);
    check("mid_replay_level", 32'(level), 32'd96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
